// File: rtl/census_disparity_match.sv
// Census disparity matcher: per pixel, picks the lowest-Hamming-cost disparity
// among the legal candidates and streams it out with a fixed 3-cycle latency.
`timescale 1ns/1ps

module census_disparity_match #(
    parameter int unsigned CENSUS_BITS = 25,
    parameter int unsigned MAX_DISP    = 16,
    parameter int unsigned DISP_W      = 4,
    parameter int unsigned COST_W      = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sol,
    input  logic [CENSUS_BITS-1:0] left_census,
    input  logic [CENSUS_BITS-1:0] right_census,
    output logic                   out_valid,
    output logic                   out_sol,
    output logic [DISP_W-1:0]      out_disp,
    output logic [COST_W-1:0]      out_cost
);

    localparam int unsigned HIST_N = MAX_DISP - 1;

    function automatic logic [COST_W-1:0] popcount(input logic [CENSUS_BITS-1:0] v);
        logic [COST_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < CENSUS_BITS; i++) begin
            n = n + COST_W'(v[i]);
        end
        return n;
    endfunction

    logic [CENSUS_BITS-1:0] rh [HIST_N];
    logic [DISP_W-1:0]      fc;

    logic [CENSUS_BITS-1:0] xor_c    [MAX_DISP];
    logic [MAX_DISP-1:0]    legal_c;

    logic [CENSUS_BITS-1:0] xor_q    [MAX_DISP];
    logic [MAX_DISP-1:0]    legal1_q;
    logic                   v1_q;
    logic                   sol1_q;

    logic [COST_W-1:0]      cost_c   [MAX_DISP];
    logic [COST_W-1:0]      cost_q   [MAX_DISP];
    logic [MAX_DISP-1:0]    legal2_q;
    logic                   v2_q;
    logic                   sol2_q;

    logic [DISP_W-1:0]      best_d_c;
    logic [COST_W-1:0]      best_cost_c;

    // Candidate XORs and legality; only right pixels of the current line are legal.
    always_comb begin
        xor_c[0]   = left_census ^ right_census;
        legal_c    = '0;
        legal_c[0] = 1'b1;
        for (int unsigned d = 1; d < MAX_DISP; d++) begin
            xor_c[d]   = left_census ^ rh[d-1];
            legal_c[d] = !in_sol && (fc >= DISP_W'(d));
        end
    end

    // Right history shift register and line fill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < HIST_N; i++) begin
                rh[i] <= '0;
            end
            fc <= '0;
        end else if (in_valid) begin
            rh[0] <= right_census;
            for (int unsigned i = 1; i < HIST_N; i++) begin
                rh[i] <= rh[i-1];
            end
            if (in_sol) begin
                fc <= DISP_W'(1);
            end else if (fc != DISP_W'(MAX_DISP - 1)) begin
                fc <= fc + DISP_W'(1);
            end
        end
    end

    // S1: XOR vectors and legal mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned d = 0; d < MAX_DISP; d++) begin
                xor_q[d] <= '0;
            end
            legal1_q <= '0;
            sol1_q   <= 1'b0;
            v1_q     <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                for (int unsigned d = 0; d < MAX_DISP; d++) begin
                    xor_q[d] <= xor_c[d];
                end
                legal1_q <= legal_c;
                sol1_q   <= in_sol;
            end
        end
    end

    always_comb begin
        for (int unsigned d = 0; d < MAX_DISP; d++) begin
            cost_c[d] = popcount(xor_q[d]);
        end
    end

    // S2: per-candidate Hamming costs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned d = 0; d < MAX_DISP; d++) begin
                cost_q[d] <= '0;
            end
            legal2_q <= '0;
            sol2_q   <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                for (int unsigned d = 0; d < MAX_DISP; d++) begin
                    cost_q[d] <= cost_c[d];
                end
                legal2_q <= legal1_q;
                sol2_q   <= sol1_q;
            end
        end
    end

    // Argmin over legal candidates; strict compare keeps the lowest d on ties.
    always_comb begin
        best_d_c    = '0;
        best_cost_c = cost_q[0];
        for (int unsigned d = 1; d < MAX_DISP; d++) begin
            if (legal2_q[d] && (cost_q[d] < best_cost_c)) begin
                best_cost_c = cost_q[d];
                best_d_c    = DISP_W'(d);
            end
        end
    end

    // S3: registered result; data holds while no result is produced.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_disp  <= '0;
            out_cost  <= '0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                out_sol  <= sol2_q;
                out_disp <= best_d_c;
                out_cost <= best_cost_c;
            end
        end
    end

endmodule

// File: tb/tb_census_disparity_match.sv
// Directed bench for census_disparity_match: expected results are attached to each
// input beat and carried through a 3-deep expectation pipe to the output.
`timescale 1ns/1ps

module tb_census_disparity_match;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_sol;
    logic [24:0] left_census;
    logic [24:0] right_census;
    logic        out_valid;
    logic        out_sol;
    logic [3:0]  out_disp;
    logic [4:0]  out_cost;

    int checks   = 0;
    int failures = 0;
    string tag   = "init";

    logic       ev [3];
    logic       es [3];
    logic [3:0] ed [3];
    logic [4:0] ec [3];
    logic       ls;
    logic [3:0] ld;
    logic [4:0] lc;

    localparam logic [24:0] ALL1 = 25'h1FFFFFF;
    localparam logic [24:0] L    = 25'h0A55A5A;
    localparam logic [24:0] M    = 25'h1337C0D;

    census_disparity_match #(
        .CENSUS_BITS(25), .MAX_DISP(16), .DISP_W(4), .COST_W(5)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sol(in_sol),
        .left_census(left_census), .right_census(right_census),
        .out_valid(out_valid), .out_sol(out_sol),
        .out_disp(out_disp), .out_cost(out_cost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] rv(input int x);
        return {5'(x + 1), 20'hA5C3E};
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 3; i++) begin
            ev[i] = 1'b0; es[i] = 1'b0; ed[i] = '0; ec[i] = '0;
        end
        ls = 1'b0; ld = '0; lc = '0;
    endtask

    task automatic check();
        checks++;
        assert (out_valid === ev[2]) else begin
            failures++;
            $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, ev[2]);
        end
        if (ev[2]) begin
            checks++;
            assert (out_disp === ed[2]) else begin
                failures++;
                $error("FAIL %s out_disp observed=%0d expected=%0d", tag, out_disp, ed[2]);
            end
            checks++;
            assert (out_cost === ec[2]) else begin
                failures++;
                $error("FAIL %s out_cost observed=%0d expected=%0d", tag, out_cost, ec[2]);
            end
            checks++;
            assert (out_sol === es[2]) else begin
                failures++;
                $error("FAIL %s out_sol observed=%0b expected=%0b", tag, out_sol, es[2]);
            end
            ls = es[2]; ld = ed[2]; lc = ec[2];
        end else begin
            checks++;
            assert (out_disp === ld && out_cost === lc && out_sol === ls) else begin
                failures++;
                $error("FAIL %s hold observed=%0d/%0d/%0b expected=%0d/%0d/%0b",
                       tag, out_disp, out_cost, out_sol, ld, lc, ls);
            end
        end
    endtask

    // One clock: present a beat (or gap) with its expected result, then check outputs.
    task automatic drive(input logic v, input logic s, input logic [24:0] l,
                         input logic [24:0] r, input logic [3:0] d, input logic [4:0] c);
        in_valid     = v;
        in_sol       = s;
        left_census  = l;
        right_census = r;
        @(posedge clk);
        ev[2] = ev[1]; es[2] = es[1]; ed[2] = ed[1]; ec[2] = ec[1];
        ev[1] = ev[0]; es[1] = es[0]; ed[1] = ed[0]; ec[1] = ec[0];
        ev[0] = v & rst; es[0] = s; ed[0] = d; ec[0] = c;
        #1;
        check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 4'd0, 5'd0);
    endtask

    initial begin
        clear_exp();
        rst = 1'b0;
        in_valid = 1'b0; in_sol = 1'b0; left_census = '0; right_census = '0;

        // 1: reset held with active input, then quiet after release
        tag = "reset";
        drive(1'b1, 1'b1, 25'h1234567, 25'h0F0F0F0, 4'd0, 5'd0);
        drive(1'b1, 1'b0, 25'h0AAAAAA, 25'h1555555, 4'd0, 5'd0);
        drive(1'b1, 1'b0, 25'h1FFFFFF, 25'h0000000, 4'd0, 5'd0);
        rst = 1'b1;
        tag = "idle";
        idle(4);

        // 2: identity line, latency 3
        tag = "identity";
        for (int x = 0; x < 8; x++) begin
            drive(1'b1, x == 0, 25'(x * 32'h0A5A5A5), 25'(x * 32'h0A5A5A5), 4'd0, 5'd0);
        end
        idle(3);

        // 3: left is right shifted by 5
        tag = "shift5";
        for (int x = 0; x < 12; x++) begin
            if (x < 5) drive(1'b1, x == 0, rv(x), rv(x), 4'd0, 5'd0);
            else       drive(1'b1, 1'b0, rv(x - 5), rv(x), 4'd5, 5'd0);
        end
        idle(3);

        // 4: previous-line data must not be used
        tag = "prevline";
        drive(1'b1, 1'b1, L, L, 4'd0, 5'd0);
        drive(1'b1, 1'b0, L, L, 4'd0, 5'd0);
        drive(1'b1, 1'b0, L, L, 4'd0, 5'd0);
        drive(1'b1, 1'b0, L, L, 4'd0, 5'd0);
        tag = "edge_x0";
        drive(1'b1, 1'b1, L, L ^ 25'h0001F00, 4'd0, 5'd5);
        tag = "edge_x1";
        drive(1'b1, 1'b0, L, L ^ 25'h0000007, 4'd0, 5'd3);
        tag = "edge_x2";
        drive(1'b1, 1'b0, L, L ^ ALL1, 4'd1, 5'd3);
        tag = "newsol";
        drive(1'b1, 1'b1, L, L ^ 25'h00000FF, 4'd0, 5'd8);
        tag = "sol_b2b";
        drive(1'b1, 1'b1, L, L ^ 25'h0000003, 4'd0, 5'd2);
        tag = "after_b2b";
        drive(1'b1, 1'b0, L, L ^ ALL1, 4'd1, 5'd2);
        idle(3);

        // 5: tie between d=2 and d=4, with gaps carrying junk and in_sol
        tag = "tie";
        drive(1'b1, 1'b1, M ^ 25'h0000003, M ^ 25'h0000003, 4'd0, 5'd0);
        drive(1'b0, 1'b1, 25'h1FFFFFF, 25'h0000000, 4'd0, 5'd0);
        drive(1'b1, 1'b0, M ^ 25'h0000F0F, M ^ 25'h0000F0F, 4'd0, 5'd0);
        drive(1'b0, 1'b1, 25'h0123456, 25'h1654321, 4'd0, 5'd0);
        drive(1'b0, 1'b0, 25'h0000000, 25'h1FFFFFF, 4'd0, 5'd0);
        drive(1'b1, 1'b0, M ^ 25'h0000030, M ^ 25'h0000030, 4'd0, 5'd0);
        drive(1'b1, 1'b0, M ^ 25'h000001F, M ^ 25'h000001F, 4'd0, 5'd0);
        drive(1'b0, 1'b1, 25'h1555555, 25'h0AAAAAA, 4'd0, 5'd0);
        drive(1'b1, 1'b0, M, M ^ ALL1, 4'd2, 5'd2);
        idle(4);

        // 5: reset with two results in flight
        tag = "midreset";
        drive(1'b1, 1'b1, 25'h0000000, 25'h00000FF, 4'd0, 5'd8);
        drive(1'b1, 1'b0, 25'h0000000, 25'h000000F, 4'd0, 5'd4);
        rst = 1'b0;
        clear_exp();
        #1;
        check();
        drive(1'b1, 1'b1, 25'h1FFFFFF, 25'h0000000, 4'd0, 5'd0);
        drive(1'b1, 1'b0, 25'h1FFFFFF, 25'h0000000, 4'd0, 5'd0);
        rst = 1'b1;
        tag = "postreset_idle";
        idle(5);

        // first beat after reset behaves as x=0 even without in_sol
        tag = "postreset_x0";
        drive(1'b1, 1'b0, 25'h0000000, 25'h000000F, 4'd0, 5'd4);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
